branch_predictor_table: RTL and testbench

- Parametrised successor to the single 2-bit Moore branch predictor.
- Holds a table of 2^INDEX_WIDTH saturating counters of CTR_WIDTH bits each.
- Indexes the table by PC, optionally XORed with a global history register (gshare mode).
- Issues registered taken/not-taken predictions, accepts resolved-branch updates and counts mispredictions.

---
 rtl/branch_predictor_table.sv | 89 ++++++++
 tb/tb_branch_predictor_table.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// Table of saturating direction counters indexed by PC (optionally gshare-hashed with global history).
// Registered predictions, resolved-branch training and a saturating misprediction counter.
module branch_predictor_table #(
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned GSHARE      = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_valid,
  input  logic [PC_WIDTH-1:0]    lookup_pc,
  output logic                   predict_valid,
  output logic                   predict,
  output logic [INDEX_WIDTH-1:0] predict_index,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_taken,
  input  logic                   update_predicted,
  output logic [INDEX_WIDTH-1:0] ghr,
  output logic [CNT_WIDTH-1:0]   mispredict_count
);

  localparam int Depth = 1 << INDEX_WIDTH;
  // Weakly not-taken: just below the taken threshold.
  localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;
  localparam logic [CTR_WIDTH-1:0] CtrOne  = 1;
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne  = 1;

  logic [CTR_WIDTH-1:0]   ctr_q [Depth];
  logic [INDEX_WIDTH-1:0] ghr_q, ghr_d;
  logic                   predict_valid_q, predict_q;
  logic [INDEX_WIDTH-1:0] predict_index_q;
  logic [CNT_WIDTH-1:0]   mispredict_count_q;

  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [CTR_WIDTH-1:0]   ctr_cur, ctr_nxt;
  logic                   mispredict;

  assign lookup_idx = lookup_pc[INDEX_WIDTH-1:0] ^ ((GSHARE != 0) ? ghr_q : '0);
  assign ctr_cur    = ctr_q[update_index];
  assign mispredict = update_valid && (update_predicted != update_taken);
  // Newest outcome enters at bit 0; the oldest falls off the top.
  assign ghr_d      = INDEX_WIDTH'({ghr_q, update_taken});

  always_comb begin
    ctr_nxt = ctr_cur;
    if (update_taken) begin
      if (ctr_cur != CtrMax) ctr_nxt = ctr_cur + CtrOne;
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CtrOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) ctr_q[i] <= CtrInit;
      ghr_q              <= '0;
      predict_valid_q    <= 1'b0;
      predict_q          <= 1'b0;
      predict_index_q    <= '0;
      mispredict_count_q <= '0;
    end else begin
      // Lookup samples pre-update table and pre-shift history (read-before-write).
      predict_valid_q <= lookup_valid;
      if (lookup_valid) begin
        predict_q       <= ctr_q[lookup_idx][CTR_WIDTH-1];
        predict_index_q <= lookup_idx;
      end
      if (update_valid) begin
        ctr_q[update_index] <= ctr_nxt;
        ghr_q               <= ghr_d;
      end
      if (mispredict && (mispredict_count_q != CntMax)) begin
        mispredict_count_q <= mispredict_count_q + CntOne;
      end
    end
  end

  assign predict_valid    = predict_valid_q;
  assign predict          = predict_q;
  assign predict_index    = predict_index_q;
  assign ghr              = ghr_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench: three instances (PC-indexed, gshare, gshare with 3-bit miss counter)
// share stimulus and are checked against a table of directed vectors and an integer model.
module tb_branch_predictor_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       lookup_valid;
  logic [7:0] lookup_pc;
  logic       update_valid;
  logic [3:0] update_index;
  logic       update_taken, update_predicted;

  logic        pv_p, pr_p, pv_g, pr_g, pv_c, pr_c;
  logic [3:0]  ix_p, ix_g, ix_c, ghr_p, ghr_g, ghr_c;
  logic [15:0] mc_p, mc_g;
  logic [2:0]  mc_c;

  int tests = 0;
  int failed = 0;

  // Reference model state
  int m_ctr[16];
  int m_ghr, m_mc;
  int e_pv, e_pp, e_ip, e_pg, e_ig;

  always #5 clk = ~clk;

  branch_predictor_table #(.GSHARE(0)) dut_p (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(pv_p), .predict(pr_p), .predict_index(ix_p), .update_valid(update_valid),
    .update_index(update_index), .update_taken(update_taken),
    .update_predicted(update_predicted), .ghr(ghr_p), .mispredict_count(mc_p)
  );

  branch_predictor_table #(.GSHARE(1)) dut_g (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(pv_g), .predict(pr_g), .predict_index(ix_g), .update_valid(update_valid),
    .update_index(update_index), .update_taken(update_taken),
    .update_predicted(update_predicted), .ghr(ghr_g), .mispredict_count(mc_g)
  );

  branch_predictor_table #(.GSHARE(1), .CNT_WIDTH(3)) dut_c (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(pv_c), .predict(pr_c), .predict_index(ix_c), .update_valid(update_valid),
    .update_index(update_index), .update_taken(update_taken),
    .update_predicted(update_predicted), .ghr(ghr_c), .mispredict_count(mc_c)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_ghr = 0; m_mc = 0;
    e_pv = 0; e_pp = 0; e_ip = 0; e_pg = 0; e_ig = 0;
  endtask

  task automatic check_all();
    check("pv_p", int'(pv_p), e_pv);
    check("pv_g", int'(pv_g), e_pv);
    check("pv_c", int'(pv_c), e_pv);
    check("pred_p", int'(pr_p), e_pp);
    check("idx_p", int'(ix_p), e_ip);
    check("pred_g", int'(pr_g), e_pg);
    check("idx_g", int'(ix_g), e_ig);
    check("pred_c", int'(pr_c), e_pg);
    check("idx_c", int'(ix_c), e_ig);
    check("ghr_p", int'(ghr_p), m_ghr);
    check("ghr_g", int'(ghr_g), m_ghr);
    check("ghr_c", int'(ghr_c), m_ghr);
    check("mcnt_p", int'(mc_p), (m_mc > 65535) ? 65535 : m_mc);
    check("mcnt_g", int'(mc_g), (m_mc > 65535) ? 65535 : m_mc);
    check("mcnt_c", int'(mc_c), (m_mc > 7) ? 7 : m_mc);
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_pc = '0; update_valid = 1'b0;
    update_index = '0; update_taken = 1'b0; update_predicted = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic cycle(input logic lv, input int pc, input logic uv, input int ui,
                       input logic ut, input logic up);
    lookup_valid = lv; lookup_pc = pc[7:0]; update_valid = uv;
    update_index = ui[3:0]; update_taken = ut; update_predicted = up;
    if (lv) begin
      e_pv = 1;
      e_ip = pc % 16;
      e_ig = (pc ^ m_ghr) % 16;
      e_pp = (m_ctr[e_ip] >= 2) ? 1 : 0;
      e_pg = (m_ctr[e_ig] >= 2) ? 1 : 0;
    end else begin
      e_pv = 0;
    end
    if (uv) begin
      if (ut) m_ctr[ui] = (m_ctr[ui] >= 3) ? 3 : m_ctr[ui] + 1;
      else    m_ctr[ui] = (m_ctr[ui] <= 0) ? 0 : m_ctr[ui] - 1;
      m_ghr = (m_ghr * 2 + int'(ut)) % 16;
      if (ut != up) m_mc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #20;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       lv;
    logic [7:0] pc;
    logic       uv;
    logic [3:0] ui;
    logic       ut, up;
    logic       pv, pp;
    logic [3:0] ip;
    logic       pg;
    logic [3:0] ig;
    logic [3:0] ghr;
  } vec_t;

  vec_t vecs[17];

  initial begin
    //           lv    pc     uv    ui    ut    up  | pv    pp    ip    pg    ig    ghr
    vecs[0]  = '{1'b1, 8'h05, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 4'h5, 4'h0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'h5, 4'h1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'h5, 4'h3};
    vecs[3]  = '{1'b1, 8'h05, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 4'h6, 4'h3};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h6, 4'h7};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h6, 4'hF};
    vecs[6]  = '{1'b1, 8'h05, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 4'hA, 4'hF};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'hA, 4'hE};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'hA, 4'hC};
    vecs[9]  = '{1'b1, 8'h05, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 4'h9, 4'hC};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'h9, 4'h9};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 4'h9, 4'h2};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'h9, 4'h5};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'h9, 4'hB};
    vecs[14] = '{1'b1, 8'h03, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 4'h8, 4'hB};
    // Same-cycle lookup and update of index 2: old counter is seen, history pre-shift.
    vecs[15] = '{1'b1, 8'h02, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 4'h9, 4'h7};
    vecs[16] = '{1'b1, 8'h02, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h5, 4'h7};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].lv, int'(vecs[i].pc), vecs[i].uv, int'(vecs[i].ui),
            vecs[i].ut, vecs[i].up);
      check($sformatf("vec%0d_pv", i), int'(pv_p), int'(vecs[i].pv));
      check($sformatf("vec%0d_pred_p", i), int'(pr_p), int'(vecs[i].pp));
      check($sformatf("vec%0d_idx_p", i), int'(ix_p), int'(vecs[i].ip));
      check($sformatf("vec%0d_pred_g", i), int'(pr_g), int'(vecs[i].pg));
      check($sformatf("vec%0d_idx_g", i), int'(ix_g), int'(vecs[i].ig));
      check($sformatf("vec%0d_ghr", i), int'(ghr_g), int'(vecs[i].ghr));
    end

    // Misprediction counting and saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, i, 1'b0, 1'b0);
    check("mcnt16_ten", int'(mc_g), 10);
    check("mcnt3_sat", int'(mc_c), 7);

    // Asynchronous reset mid-stream, observed before any clock edge.
    do_reset();
    cycle(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
    cycle(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
    check("pre_rst_pred", int'(pr_p), 1);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("async_pv", int'(pv_p), 0);
    check("async_pred", int'(pr_p), 0);
    check("async_ghr", int'(ghr_g), 0);
    check("async_mcnt", int'(mc_g), 0);
    model_reset();
    #10;
    reset = 1'b1;
    cycle(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_pred", int'(pr_p), 0);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
